// File: rtl/head_ptr_decoder_pkg.sv
// Shared definitions for the head/state-select pointer: command encodings and
// the supported range of the binary position width.
package head_ptr_pkg;

    localparam int unsigned SEL_W_MIN = 1;
    localparam int unsigned SEL_W_MAX = 6;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_LEFT  = 2'b10,
        OP_RIGHT = 2'b11
    } cmd_op_e;

endpackage

// File: rtl/head_ptr_decoder_if.sv
// Command and status bundle between a pointer client (master) and the
// head_ptr_decoder block (slave).
interface head_ptr_decoder_if #(
    parameter int unsigned SEL_W = 3
);
    localparam int unsigned OUT_W = 2 ** SEL_W;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [SEL_W-1:0] cmd_idx;
    logic [OUT_W-1:0] sel_onehot;
    logic [SEL_W-1:0] pos;
    logic             active;
    logic             at_min;
    logic             at_max;
    logic             edge_hit;
    logic             cmd_err;

    modport master (
        output cmd_valid, cmd_op, cmd_idx,
        input  cmd_ready, sel_onehot, pos, active, at_min, at_max, edge_hit, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_idx,
        output cmd_ready, sel_onehot, pos, active, at_min, at_max, edge_hit, cmd_err
    );

endinterface

// File: rtl/head_ptr_decoder_onehot.sv
// Combinational binary-to-one-hot decoder with enable; all-zero when disabled.
module onehot_decoder #(
    parameter int unsigned SEL_W = 3
) (
    input  logic                  en,
    input  logic [SEL_W-1:0]      idx,
    output logic [2**SEL_W-1:0]   onehot_c
);

    always_comb begin
        onehot_c = '0;
        if (en) begin
            onehot_c[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/head_ptr_decoder.sv
// Registered one-hot pointer with load/step commands over a valid/ready port.
// Define HEAD_PTR_WRAP_EN for modulo stepping; default build saturates at the edges.
module head_ptr_decoder
    import head_ptr_pkg::*;
#(
    parameter int unsigned SEL_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    head_ptr_decoder_if.slave  bus
);

    localparam int unsigned OUT_W = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] POS_MAX = {SEL_W{1'b1}};
    localparam logic [SEL_W-1:0] POS_MIN = '0;

    typedef enum logic {
        ST_INACTIVE = 1'b0,
        ST_ACTIVE   = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] pos_q, pos_d;
    logic [OUT_W-1:0] sel_q, sel_d;
    logic             ready_q;
    logic             at_min_q, at_min_d;
    logic             at_max_q, at_max_d;
    logic             edge_hit_q, edge_hit_d;
    logic             cmd_err_q, cmd_err_d;
    logic             accept;
    logic             active_d;
    cmd_op_e          op;

    assign op = cmd_op_e'(bus.cmd_op);

    // State and every output are flops; sel/edge flags are computed from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INACTIVE;
            pos_q      <= '0;
            sel_q      <= '0;
            ready_q    <= 1'b0;
            at_min_q   <= 1'b0;
            at_max_q   <= 1'b0;
            edge_hit_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            sel_q      <= sel_d;
            ready_q    <= 1'b1;
            at_min_q   <= at_min_d;
            at_max_q   <= at_max_d;
            edge_hit_q <= edge_hit_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        edge_hit_d = 1'b0;
        cmd_err_d  = 1'b0;
        accept     = bus.cmd_valid & ready_q & ~clr;

        if (clr) begin
            state_d = ST_INACTIVE;
            pos_d   = '0;
        end else if (accept) begin
            case (op)
                OP_LOAD: begin
                    pos_d   = bus.cmd_idx;
                    state_d = ST_ACTIVE;
                end
                OP_LEFT: begin
                    if (state_q != ST_ACTIVE) begin
                        cmd_err_d = 1'b1;
                    end else if (pos_q == POS_MIN) begin
                        edge_hit_d = 1'b1;
`ifdef HEAD_PTR_WRAP_EN
                        pos_d = POS_MAX;
`else
                        pos_d = POS_MIN;
`endif
                    end else begin
                        pos_d = pos_q - SEL_W'(1);
                    end
                end
                OP_RIGHT: begin
                    if (state_q != ST_ACTIVE) begin
                        cmd_err_d = 1'b1;
                    end else if (pos_q == POS_MAX) begin
                        edge_hit_d = 1'b1;
`ifdef HEAD_PTR_WRAP_EN
                        pos_d = POS_MIN;
`else
                        pos_d = POS_MAX;
`endif
                    end else begin
                        pos_d = pos_q + SEL_W'(1);
                    end
                end
                default: ;
            endcase
        end

        active_d = (state_d == ST_ACTIVE);
        at_min_d = active_d & (pos_d == POS_MIN);
        at_max_d = active_d & (pos_d == POS_MAX);
    end

    onehot_decoder #(
        .SEL_W (SEL_W)
    ) u_sel_dec (
        .en       (active_d),
        .idx      (pos_d),
        .onehot_c (sel_d)
    );

    assign bus.cmd_ready  = ready_q;
    assign bus.pos        = pos_q;
    assign bus.active     = (state_q == ST_ACTIVE);
    assign bus.sel_onehot = sel_q;
    assign bus.at_min     = at_min_q;
    assign bus.at_max     = at_max_q;
    assign bus.edge_hit   = edge_hit_q;
    assign bus.cmd_err    = cmd_err_q;

    // Select integrity and parameter range.
    a_sel_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_ACTIVE) |-> $onehot(sel_q));
    a_sel_w_range: assert property (@(posedge clk)
        (SEL_W >= SEL_W_MIN) && (SEL_W <= SEL_W_MAX));

endmodule

// File: doc/head_ptr_decoder.md
# head_ptr_decoder

Registered, parametrised binary-to-one-hot pointer for the tape head and state-select paths. It holds the current position and accepts load, step-left and step-right commands over a valid/ready port. It drives a one-hot select vector of width 2**SEL_W alongside the binary position and edge flags. It replaces free-standing combinational 3-to-8 decoding wherever the select must persist or move by one cell per cycle.

## Interface
- SEL_W, 3, binary position width; OUT_W = 2**SEL_W one-hot outputs (SEL_W 1..6)
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear; highest priority
- cmd_valid  in  1  command present
- cmd_ready  out  1  block accepts command this cycle
- cmd_op  in  2  00 NOP, 01 LOAD, 10 LEFT (decrement), 11 RIGHT (increment)
- cmd_idx  in  SEL_W  LOAD target position; ignored for other ops
- sel_onehot  out  OUT_W  one-hot of pos when active, all-zero when inactive
- pos  out  SEL_W  binary position
- active  out  1  pointer loaded and valid
- at_min / at_max  out  1  pos == 0 / pos == OUT_W-1, gated by active
- edge_hit  out  1  one-cycle pulse: step attempted past an edge
- cmd_err  out  1  one-cycle pulse: step accepted while inactive

## Operation
- Accept = cmd_valid & cmd_ready & ~clr.
- LOAD: pos <= cmd_idx, active <= 1.
- LEFT/RIGHT when active: pos -/+ 1 modulo or saturated (see Configuration).
- LEFT/RIGHT when inactive: no state change; cmd_err pulses.
- NOP: no state change, no pulses.
- clr: active <= 0, pos <= 0, pending pulses suppressed; a command presented in the same cycle is dropped.
- sel_onehot[i] = active & (pos == i); exactly one bit set when active.
- Integrity: any cycle with active=1 and popcount(sel_onehot) != 1 is a design error, checked by assertion.

## Timing
- Reset values (asynchronous): pos=0, active=0, sel_onehot=0, at_min=0, at_max=0, edge_hit=0, cmd_err=0, cmd_ready=0.
- cmd_ready registered: rises on the first clk edge after rst_n deasserts, then stays 1.
- Latency 1: a command accepted at edge N is reflected on all outputs after edge N. Back-to-back commands apply one per cycle.
- edge_hit and cmd_err are high for exactly the cycle after the offending accept.
- Reset asserted mid-operation clears everything immediately, regardless of clk.

## Configuration
- HEAD_PTR_WRAP_EN defined: LEFT at pos 0 gives OUT_W-1, and RIGHT at OUT_W-1 gives 0. edge_hit still pulses on each wrap.
- HEAD_PTR_WRAP_EN undefined: steps saturate and pos holds at the edge. edge_hit pulses on each blocked step.

## Structure
- Shared package head_ptr_pkg holds the cmd_op encodings (OP_NOP, OP_LOAD, OP_LEFT, OP_RIGHT) and the SEL_W range limits.
- Sub-module onehot_decoder: purely combinational SEL_W-to-OUT_W decoder with enable. It is instantiated once for sel_onehot.

## Test plan
- Reset release, SEL_W=3 -> all outputs 0, cmd_ready 1 after first edge, sel_onehot 8'h00.
- LOAD 5 then RIGHT -> after edges: pos 5 / sel 8'h20, then pos 6 / sel 8'h40, no pulses.
- LOAD 7 then RIGHT:
  - with wrap -> pos 0, sel 8'h01, edge_hit 1 cycle;
  - without wrap -> pos 7, at_max 1, edge_hit 1 cycle.
- RIGHT while inactive -> cmd_err 1 cycle, sel_onehot 8'h00, pos 0.
- clr asserted together with LOAD 3 -> active 0, pos 0, no pulses; next-cycle LOAD 3 -> sel 8'h08.
- rst_n dropped between clock edges after LOAD 4 -> outputs 0 immediately, cmd_ready 0 until first edge after release.
